// File: rtl/alu_share_arbiter_if.sv
// Requester, ALU and response signals shared between alu_share_arbiter and its environment.
interface alu_share_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [3:0]       req0_funct;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [3:0]       req1_funct;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [3:0]       alu_functc;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;
  logic             rsp_err;
  logic             busy;

  modport slave (
    input  req_valid, req0_funct, req0_a, req0_b, req1_funct, req1_a, req1_b,
           alu_out, rsp_ready,
    output req_ready, alu_functc, alu_a, alu_b, rsp_valid, rsp_id, rsp_data,
           rsp_zero, rsp_err, busy
  );

  modport master (
    output req_valid, req0_funct, req0_a, req0_b, req1_funct, req1_a, req1_b,
           alu_out, rsp_ready,
    input  req_ready, alu_functc, alu_a, alu_b, rsp_valid, rsp_id, rsp_data,
           rsp_zero, rsp_err, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with
// registered operands held through execution and a registered valid/ready response.
module alu_share_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SIMPLE_LAT = 1,
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_share_arbiter_if.slave  bus
);
  localparam int unsigned MAX_LAT = (SIMPLE_LAT > MULDIV_LAT) ? SIMPLE_LAT : MULDIV_LAT;
  localparam int unsigned CW      = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             last_grant;
  logic             grant;
  logic             any_valid;
  logic             accept;
  logic [3:0]       sel_funct;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_legal;
  logic             sel_muldiv;
  logic             sel_div0;
  logic [CW-1:0]    cnt;
  logic [3:0]       op_funct;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_zero_q;
  logic             rsp_err_q;

  // Pick the winner (tie goes to the requester not served last) and decode its op.
  always_comb begin
    any_valid  = |bus.req_valid;
    grant      = (&bus.req_valid) ? ~last_grant : bus.req_valid[1];
    sel_funct  = grant ? bus.req1_funct : bus.req0_funct;
    sel_a      = grant ? bus.req1_a     : bus.req0_a;
    sel_b      = grant ? bus.req1_b     : bus.req0_b;
    sel_legal  = 1'b0;
    case (sel_funct)
      4'b0010, 4'b0110, 4'b0000, 4'b0001,
      4'b0011, 4'b0100, 4'b1010, 4'b1111: sel_legal = 1'b1;
      default:                            sel_legal = 1'b0;
    endcase
    sel_muldiv = (sel_funct == 4'b1010) || (sel_funct == 4'b1111);
    sel_div0   = (sel_funct == 4'b1111) && (sel_b == '0);
    accept     = (state == IDLE) && any_valid;
  end

  // Next state: error ops bypass EXEC straight to the response.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_valid) state_next = (!sel_legal || sel_div0) ? RESP : EXEC;
      EXEC:    if (cnt == '0) state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Capture the granted op, count EXEC cycles and register the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      cnt        <= '0;
      op_funct   <= '0;
      op_a       <= '0;
      op_b       <= '0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else if (accept) begin
      last_grant <= grant;
      rsp_id_q   <= grant;
      op_funct   <= sel_funct;
      op_a       <= sel_a;
      op_b       <= sel_b;
      cnt        <= sel_muldiv ? CW'(MULDIV_LAT - 1) : CW'(SIMPLE_LAT - 1);
      if (!sel_legal) begin
        rsp_data_q <= '0;
        rsp_zero_q <= 1'b0;
        rsp_err_q  <= 1'b1;
      end else if (sel_div0) begin
        rsp_data_q <= '1;
        rsp_zero_q <= 1'b0;
        rsp_err_q  <= 1'b1;
      end
    end else if (state == EXEC) begin
      if (cnt == '0) begin
        rsp_data_q <= bus.alu_out;
        rsp_zero_q <= (bus.alu_out == '0);
        rsp_err_q  <= 1'b0;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign bus.req_ready  = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign bus.alu_functc = op_funct;
  assign bus.alu_a      = op_a;
  assign bus.alu_b      = op_b;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.busy       = (state != IDLE);
endmodule
